// File: rtl/sram_access_arbiter.sv
// Arbitrates the single asynchronous SRAM between the Avalon-MM CPU slave and a req/ack
// hardware requester, sequencing the SRAM strobes and returning read data to the winner.
module sram_access_arbiter #(
  parameter int unsigned ADDR_W        = 18,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hw_enable,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic [1:0]        cpu_byteenable,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  input  logic              hw_req,
  input  logic              hw_we,
  input  logic [ADDR_W-1:0] hw_addr,
  input  logic [DATA_W-1:0] hw_wdata,
  output logic              hw_ack,
  output logic [DATA_W-1:0] hw_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int unsigned CntW = 4;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam logic OwnCpu = 1'b0;
  localparam logic OwnHw  = 1'b1;

  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
  logic [1:0]             state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic [1:0]             be_q, be_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]      cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]      hw_rdata_q, hw_rdata_d;

  logic en_s;
  logic cpu_pend;
  logic hw_pend;
  logic grant_hw;
  logic in_access;
  logic in_done;

  assign en_sync_d = {en_sync_q[SYNC_STAGES-2:0], hw_enable};
  assign en_s      = en_sync_q[SYNC_STAGES-1];
  assign cpu_pend  = cpu_read | cpu_write;
  assign hw_pend   = hw_req & en_s;
  // On contention the side that did not win last time gets the SRAM.
  assign grant_hw  = hw_pend & (~cpu_pend | (last_grant_q == OwnCpu));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    be_d         = be_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    hw_rdata_d   = hw_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_pend || hw_pend) begin
          state_d      = StAccess;
          owner_d      = grant_hw;
          last_grant_d = grant_hw;
          cnt_d        = CntW'(ACCESS_CYCLES - 1);
          if (grant_hw) begin
            addr_d  = hw_addr;
            wdata_d = hw_wdata;
            we_d    = hw_we;
            be_d    = 2'b11;
          end else begin
            addr_d  = cpu_address;
            wdata_d = cpu_writedata;
            we_d    = cpu_write;
            be_d    = cpu_byteenable;
          end
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          if (!we_q) begin
            if (owner_q == OwnHw) hw_rdata_d  = sram_dq_in;
            else                  cpu_rdata_d = sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_sync_q    <= '0;
      state_q      <= StIdle;
      owner_q      <= OwnCpu;
      last_grant_q <= OwnHw;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      be_q         <= 2'b00;
      cnt_q        <= '0;
      cpu_rdata_q  <= '0;
      hw_rdata_q   <= '0;
    end else begin
      en_sync_q    <= en_sync_d;
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      be_q         <= be_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      hw_rdata_q   <= hw_rdata_d;
    end
  end

  // Strobes decode straight from flops so async reset drops them immediately.
  assign in_access = (state_q == StAccess);
  assign in_done   = (state_q == StDone);

  always_comb begin
    sram_ce_n       = ~in_access;
    sram_we_n       = ~(in_access & we_q);
    sram_oe_n       = ~(in_access & ~we_q);
    sram_dq_oe      = in_access & we_q;
    sram_ub_n       = ~(in_access & be_q[1]);
    sram_lb_n       = ~(in_access & be_q[0]);
    sram_addr       = addr_q;
    sram_dq_out     = wdata_q;
    cpu_waitrequest = ~(in_done & (owner_q == OwnCpu));
    cpu_readdata    = cpu_rdata_q;
    hw_ack          = in_done & (owner_q == OwnHw);
    hw_rdata        = hw_rdata_q;
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: directed vector table, hand-written corner sequences and a
// randomized transaction run scored against a word-level memory/arbitration model.
module tb_sram_access_arbiter;

  localparam int AC = 2;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hw_enable;
  logic [17:0] cpu_address;
  logic        cpu_read, cpu_write;
  logic [15:0] cpu_writedata;
  logic [1:0]  cpu_byteenable;
  logic [15:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic        hw_req, hw_we;
  logic [17:0] hw_addr;
  logic [15:0] hw_wdata;
  logic        hw_ack;
  logic [15:0] hw_rdata;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  sram_access_arbiter #(
    .ADDR_W(18), .DATA_W(16), .ACCESS_CYCLES(AC), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hw_enable(hw_enable),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .hw_req(hw_req), .hw_we(hw_we), .hw_addr(hw_addr), .hw_wdata(hw_wdata),
    .hw_ack(hw_ack), .hw_rdata(hw_rdata),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // Simple asynchronous SRAM: byte-lane writes while we_n is low, reads driven while oe_n is low.
  bit [15:0] sram_mem [0:(1<<18)-1];

  always @(posedge clk) begin
    if (reset_n && !sram_ce_n && !sram_we_n) begin
      if (!sram_ub_n) sram_mem[sram_addr][15:8] <= sram_dq_out[15:8];
      if (!sram_lb_n) sram_mem[sram_addr][7:0]  <= sram_dq_out[7:0];
    end
  end

  always @(negedge clk) begin
    sram_dq_in <= (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0BAD;
  end

  // Bus monitor: strobe activity counters, completion order and invariant violations.
  int   we_low_cnt = 0, we_fall_cnt = 0, ub_low_cnt = 0, lb_low_cnt = 0;
  int   cpu_done_cnt = 0, hw_ack_cnt = 0, inv_bad = 0;
  logic we_n_prev = 1'b1;
  byte  order_q[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (!sram_we_n) we_low_cnt <= we_low_cnt + 1;
      if (!sram_we_n && we_n_prev) we_fall_cnt <= we_fall_cnt + 1;
      if (!sram_ub_n) ub_low_cnt <= ub_low_cnt + 1;
      if (!sram_lb_n) lb_low_cnt <= lb_low_cnt + 1;
      if (!cpu_waitrequest) begin
        cpu_done_cnt <= cpu_done_cnt + 1;
        order_q.push_back(8'h43);
      end
      if (hw_ack) begin
        hw_ack_cnt <= hw_ack_cnt + 1;
        order_q.push_back(8'h48);
      end
      if ((!sram_we_n && !sram_oe_n) || (sram_dq_oe && sram_we_n)) inv_bad <= inv_bad + 1;
    end
    we_n_prev <= sram_we_n;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Word-level reference memory and arbitration history.
  bit [15:0] ref_mem [bit [17:0]];
  bit        model_last_hw;

  function automatic bit [15:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  function automatic void ref_wr(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
    bit [15:0] w;
    w = ref_rd(a);
    if (be[1]) w[15:8] = d[15:8];
    if (be[0]) w[7:0]  = d[7:0];
    ref_mem[a] = w;
  endfunction

  // Both tasks are entered just after a rising edge; lat counts cycles from the request cycle.
  task automatic cpu_op(input bit we, input logic [17:0] a, input logic [15:0] d,
                        input logic [1:0] be, output logic [15:0] rd, output int lat,
                        output time t);
    int n = 0;
    cpu_address = a; cpu_writedata = d; cpu_byteenable = be;
    cpu_write = we; cpu_read = ~we;
    lat = -1; rd = '0; t = 0;
    while (lat < 0 && n <= 40) begin
      @(negedge clk);
      if (!cpu_waitrequest) begin
        rd = cpu_readdata; lat = n; t = $time;
      end else n++;
    end
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic hw_op(input bit we, input logic [17:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output int lat, output time t);
    int n = 0;
    hw_we = we; hw_addr = a; hw_wdata = d; hw_req = 1'b1;
    lat = -1; rd = '0; t = 0;
    while (lat < 0 && n <= 40) begin
      @(negedge clk);
      if (hw_ack) begin
        rd = hw_rdata; lat = n; t = $time;
      end else n++;
    end
    @(posedge clk); #1;
    hw_req = 1'b0;
  endtask

  typedef struct {
    bit          we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rd;
  } cpu_vec_t;

  cpu_vec_t    vec [7];
  logic [15:0] rd_c, rd_h, exp_c, exp_h;
  int          lat_c, lat_h, snap_a, snap_b, snap_c, snap_d, snap_e, base, n;
  time         t_c, t_h;
  logic [31:0] ord;
  int unsigned kind;
  bit          cw, hwe, cpu_first;
  logic [17:0] ca, ha;
  logic [15:0] cd, hd;
  logic [1:0]  cbe;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{1'b1, 18'h00010, 16'hBEEF, 2'b11, 16'h0000};
    vec[1] = '{1'b0, 18'h00010, 16'h0000, 2'b11, 16'hBEEF};
    vec[2] = '{1'b1, 18'h00020, 16'h5555, 2'b11, 16'h0000};
    vec[3] = '{1'b1, 18'h00020, 16'hAAAA, 2'b01, 16'h0000};
    vec[4] = '{1'b0, 18'h00020, 16'h0000, 2'b11, 16'h55AA};
    vec[5] = '{1'b1, 18'h00030, 16'h12AB, 2'b10, 16'h0000};
    vec[6] = '{1'b0, 18'h00030, 16'h0000, 2'b11, 16'h1200};

    reset_n = 1'b0; hw_enable = 1'b0;
    cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0;
    cpu_byteenable = 2'b00; hw_req = 1'b0; hw_we = 1'b0; hw_addr = '0; hw_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
    check("reset_addr_dq", {sram_addr, sram_dq_out, sram_dq_oe}, '0);
    check("reset_waitrequest", cpu_waitrequest, 1'b1);
    check("reset_ack_rdata", {hw_ack, hw_rdata, cpu_readdata}, '0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed CPU vectors: write/read-back, partial byte writes.
    for (int i = 0; i < 7; i++) begin
      snap_a = we_low_cnt; snap_b = we_fall_cnt; snap_c = ub_low_cnt; snap_d = lb_low_cnt;
      cpu_op(vec[i].we, vec[i].addr, vec[i].wdata, vec[i].be, rd_c, lat_c, t_c);
      check($sformatf("vec%0d_latency", i), lat_c, AC + 1);
      if (!vec[i].we) check($sformatf("vec%0d_rdata", i), rd_c, vec[i].exp_rd);
      check($sformatf("vec%0d_we_low", i), we_low_cnt - snap_a, vec[i].we ? AC : 0);
      check($sformatf("vec%0d_we_pulses", i), we_fall_cnt - snap_b, vec[i].we ? 1 : 0);
      check($sformatf("vec%0d_ub_low", i), ub_low_cnt - snap_c, vec[i].be[1] ? AC : 0);
      check($sformatf("vec%0d_lb_low", i), lb_low_cnt - snap_d, vec[i].be[0] ? AC : 0);
    end

    // Hardware write then read at the top address.
    hw_enable = 1'b1;
    repeat (SS + 1) @(posedge clk);
    #1;
    snap_a = hw_ack_cnt;
    hw_op(1'b1, 18'h3FFFF, 16'h1234, rd_h, lat_h, t_h);
    check("hw_write_latency", lat_h, AC + 1);
    hw_op(1'b0, 18'h3FFFF, 16'h0000, rd_h, lat_h, t_h);
    check("hw_read_latency", lat_h, AC + 1);
    check("hw_read_data", rd_h, 16'h1234);
    check("hw_ack_pulses", hw_ack_cnt - snap_a, 2);
    repeat (2) @(posedge clk);
    #1;
    check("hw_rdata_held", hw_rdata, 16'h1234);

    // Simultaneous requests alternate, CPU first since hardware won last.
    base = order_q.size();
    fork
      begin
        cpu_op(1'b0, 18'h00010, 16'h0, 2'b11, rd_c, lat_c, t_c);
        check("rr_cpu0_data", rd_c, 16'hBEEF);
        cpu_op(1'b0, 18'h00010, 16'h0, 2'b11, rd_c, lat_c, t_c);
      end
      begin
        hw_op(1'b0, 18'h3FFFF, 16'h0, rd_h, lat_h, t_h);
        hw_op(1'b0, 18'h3FFFF, 16'h0, rd_h, lat_h, t_h);
      end
    join
    ord = '0;
    for (int k = 0; k < 4; k++)
      ord = {ord[23:0], (base + k < order_q.size()) ? order_q[base + k] : 8'h3F};
    check("rr_grant_order", ord, {8'h43, 8'h48, 8'h43, 8'h48});
    check("rr_hw1_data", rd_h, 16'h1234);

    // Enable low: hardware held off while CPU is still served; then grant after enable rises.
    hw_enable = 1'b0;
    repeat (SS + 2) @(posedge clk);
    #1;
    snap_a = hw_ack_cnt;
    hw_we = 1'b0; hw_addr = 18'h3FFFF; hw_req = 1'b1;
    cpu_op(1'b0, 18'h00020, 16'h0, 2'b11, rd_c, lat_c, t_c);
    check("dis_cpu_latency", lat_c, AC + 1);
    check("dis_cpu_data", rd_c, 16'h55AA);
    repeat (6) @(posedge clk);
    #1;
    check("dis_no_hw_ack", hw_ack_cnt - snap_a, 0);
    check("dis_sram_idle", sram_ce_n, 1'b1);
    hw_enable = 1'b1;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (!sram_ce_n) break;
      n++;
    end
    check("en_grant_within_sync", (n >= 1 && n <= SS + 1), 1'b1);
    n = 0;
    while (!hw_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("en_hw_ack_seen", hw_ack, 1'b1);
    check("en_hw_data", hw_rdata, 16'h1234);
    @(posedge clk); #1;
    hw_req = 1'b0;

    // Random transactions against the word-level model in a region untouched above.
    cpu_op(1'b0, 18'h00100, 16'h0, 2'b11, rd_c, lat_c, t_c);
    check("rand_warmup", rd_c, ref_rd(18'h00100));
    model_last_hw = 1'b0;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      cw   = 1'($urandom_range(0, 1));
      hwe  = 1'($urandom_range(0, 1));
      ca   = 18'h00100 + 18'($urandom_range(0, 7));
      ha   = 18'h00100 + 18'($urandom_range(0, 7));
      cd   = 16'($urandom);
      hd   = 16'($urandom);
      cbe  = 2'($urandom_range(1, 3));
      if (kind == 0) begin
        exp_c = ref_rd(ca);
        cpu_op(cw, ca, cd, cbe, rd_c, lat_c, t_c);
        if (cw) ref_wr(ca, cd, cbe);
        else check($sformatf("rand%0d_cpu_data", i), rd_c, exp_c);
        check($sformatf("rand%0d_cpu_lat", i), lat_c, AC + 1);
        model_last_hw = 1'b0;
      end else if (kind == 1) begin
        exp_h = ref_rd(ha);
        hw_op(hwe, ha, hd, rd_h, lat_h, t_h);
        if (hwe) ref_wr(ha, hd, 2'b11);
        else check($sformatf("rand%0d_hw_data", i), rd_h, exp_h);
        check($sformatf("rand%0d_hw_lat", i), lat_h, AC + 1);
        model_last_hw = 1'b1;
      end else begin
        cpu_first = model_last_hw;
        fork
          cpu_op(cw, ca, cd, cbe, rd_c, lat_c, t_c);
          hw_op(hwe, ha, hd, rd_h, lat_h, t_h);
        join
        check($sformatf("rand%0d_winner", i), (t_c < t_h), cpu_first);
        if (cpu_first) begin
          exp_c = ref_rd(ca);
          if (cw) ref_wr(ca, cd, cbe);
          exp_h = ref_rd(ha);
          if (hwe) ref_wr(ha, hd, 2'b11);
        end else begin
          exp_h = ref_rd(ha);
          if (hwe) ref_wr(ha, hd, 2'b11);
          exp_c = ref_rd(ca);
          if (cw) ref_wr(ca, cd, cbe);
        end
        if (!cw)  check($sformatf("rand%0d_both_cpu_data", i), rd_c, exp_c);
        if (!hwe) check($sformatf("rand%0d_both_hw_data", i), rd_h, exp_h);
        check($sformatf("rand%0d_both_lat", i), cpu_first ? lat_h : lat_c, 2 * AC + 3);
        model_last_hw = cpu_first;
      end
    end

    // Reset in the second ACCESS cycle of a CPU write.
    snap_a = cpu_done_cnt; snap_e = hw_ack_cnt;
    cpu_address = 18'h00040; cpu_writedata = 16'h7777; cpu_byteenable = 2'b11;
    cpu_write = 1'b1; cpu_read = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (!sram_ce_n) break;
      n++;
    end
    @(posedge clk); #2;
    check("rst_mid_write_active", sram_we_n, 1'b0);
    reset_n = 1'b0; cpu_write = 1'b0;
    #1;
    check("rst_strobes_off", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
    check("rst_dq_oe_off", sram_dq_oe, 1'b0);
    check("rst_waitrequest", cpu_waitrequest, 1'b1);
    check("rst_no_ack", hw_ack, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_completion", (cpu_done_cnt - snap_a) + (hw_ack_cnt - snap_e), 0);
    check("bus_invariants", inv_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
